debug_word_serializer: RTL and testbench
========================================

DEBUG_WORD_SERIALIZER -- requirements
Module: debug_word_serializer

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 32, giving the input word width in bits; the value SHALL be a multiple of 8 and at least 16.
REQ-002 The block SHALL have port clock, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-003 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-004 The block SHALL have port in_data, input, DATA_WIDTH bits: the word to be serialized.
REQ-005 The block SHALL have port in_valid, input, 1 bit: in_data is valid.
REQ-006 The block SHALL have port in_ready, output, 1 bit: the block can accept a word.
REQ-007 The block SHALL have port out_data, output, 8 bits: the current byte, which feeds the LED debugger queue input.
REQ-008 The block SHALL have port out_valid, output, 1 bit: out_data is valid.
REQ-009 The block SHALL have port out_ready, input, 1 bit: the downstream stage accepts the byte.
REQ-010 The block SHALL have port busy, output, 1 bit: high while a word is held, from acceptance until its last byte is handed off.

Function
REQ-011 Handshakes SHALL follow the codebase fifo valid/ready rule: a transfer occurs on a cycle where valid and ready are both high.
REQ-012 The FSM SHALL have the states IDLE, MARKER and SHIFT; the MARKER state SHALL exist only with DEBUG_SERIALIZER_MARKER_EN defined.
REQ-013 In IDLE, in_ready SHALL be 1, out_valid SHALL be 0 and busy SHALL be 0; in every other state, in_ready SHALL be 0 and busy SHALL be 1.
REQ-014 An input transfer in IDLE SHALL:
- latch in_data into a DATA_WIDTH-bit shift register;
- load the byte counter with DATA_WIDTH/8;
- move to MARKER if enabled, otherwise to SHIFT, on the next edge.
REQ-015 The first output byte SHALL be valid the cycle after the input transfer (latency 1).
REQ-016 In SHIFT, out_valid SHALL be 1 and out_data SHALL equal the top 8 bits of the shift register, so bytes are sent MSB byte first.
REQ-017 While out_valid is 1 and out_ready is 0, out_data SHALL stay stable and out_valid SHALL stay high.
REQ-018 On an output transfer in SHIFT, the shift register SHALL shift left by 8, filling with zeros, and the counter SHALL decrement by 1.
REQ-019 On the output transfer of the last byte (counter equal to 1), the state SHALL return to IDLE, with in_ready high the next cycle.
REQ-020 Minimum cost per word SHALL be DATA_WIDTH/8 + 1 cycles, or + 2 with the marker; back-to-back acceptance in the same cycle as the last-byte handoff SHALL NOT occur.
REQ-021 The counter SHALL be clog2(DATA_WIDTH/8)+1 bits wide and SHALL never wrap: it stops at 1, then the state returns to IDLE.
REQ-022 in_valid in any non-IDLE state SHALL be ignored, and in_data SHALL not affect the held word.
REQ-023 Deassertion of out_ready for any number of cycles SHALL not lose, duplicate or reorder bytes.

Reset
REQ-024 When reset is high at a clock edge:
- state SHALL become IDLE;
- out_valid, out_data, busy, the counter and the shift register SHALL become 0;
- in_ready SHALL be 1 the following cycle.
REQ-025 Reset mid-word SHALL discard the remaining bytes, and out_valid SHALL be 0 on the cycle after reset is sampled.
REQ-026 Reset SHALL take priority over any simultaneous handshake.

Configuration
REQ-027 With macro DEBUG_SERIALIZER_MARKER_EN defined:
- each accepted word SHALL first emit one marker byte 8'hA5 in state MARKER, under the REQ-017 hold rule;
- after the marker transfer, the state SHALL move to SHIFT.
REQ-028 Without DEBUG_SERIALIZER_MARKER_EN, no marker byte SHALL be emitted and the MARKER state SHALL not be synthesized.

Structure
REQ-029 The shared debug package SHALL hold the marker constant DEBUG_MARKER_BYTE = 8'hA5 and the FSM state encodings.
REQ-030 The block SHALL be a single module with no sub-module; it is instantiated directly upstream of led_debugger.

Verification
REQ-031 Marker off, word 32'h12345678, out_ready held 1 -> bytes 12, 34, 56, 78 on four consecutive cycles starting one cycle after acceptance; in_ready high the cycle after the 78 transfer.
REQ-032 Marker on, same word -> bytes A5, 12, 34, 56, 78 in that order.
REQ-033 out_ready toggled 1,0,0,1,0,1,... during word 32'hDEADBEEF -> exactly DE, AD, BE, EF delivered; out_data stable whenever out_valid is 1 and out_ready is 0.
REQ-034 in_valid held high with words 32'h00000001 then 32'hFFFFFFFF -> second word accepted only in IDLE; output 00, 00, 00, 01, FF, FF, FF, FF; no byte of the second word appears early.
REQ-035 Reset asserted after byte 34 of 32'h12345678 -> out_valid 0 next cycle, no 56/78 ever emitted; a new word 32'hCAFEF00D then yields CA, FE, F0, 0D.
REQ-036 DATA_WIDTH=16, word 16'hBEEF -> BE, EF; busy high from the cycle after acceptance until the EF transfer.

Source files
------------

// File: rtl/debug_word_serializer_pkg.sv
// Shared constants and FSM encodings for the debug word serializer.
// MARKER exists only when DEBUG_SERIALIZER_MARKER_EN is defined.
package debug_word_serializer_pkg;

  localparam logic [7:0] DEBUG_MARKER_BYTE = 8'hA5;

`ifdef DEBUG_SERIALIZER_MARKER_EN
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    MARKER = 2'd1,
    SHIFT  = 2'd2
  } state_t;
`else
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd2
  } state_t;
`endif

endpackage

// File: rtl/debug_word_serializer.sv
// Serializes one DATA_WIDTH word into bytes (MSB byte first) for the LED debugger queue.
// Optional marker byte before each word: define DEBUG_SERIALIZER_MARKER_EN.
module debug_word_serializer
  import debug_word_serializer_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [7:0]            out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  busy
);

  localparam int NUM_BYTES = DATA_WIDTH / 8;
  localparam int CNT_W     = $clog2(NUM_BYTES) + 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(NUM_BYTES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(1);

  state_t                  state_reg;
  logic [DATA_WIDTH-1:0]   shift_reg;
  logic [CNT_W-1:0]        count_reg;
  logic [7:0]              out_data_reg;
  logic                    out_valid_reg;
  logic                    in_ready_reg;
  logic                    busy_reg;

  assign in_ready  = in_ready_reg;
  assign out_data  = out_data_reg;
  assign out_valid = out_valid_reg;
  assign busy      = busy_reg;

  // Outputs are registered: each branch loads the value the next state will present.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg     <= IDLE;
      shift_reg     <= '0;
      count_reg     <= '0;
      out_data_reg  <= '0;
      out_valid_reg <= 1'b0;
      in_ready_reg  <= 1'b1;
      busy_reg      <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (in_valid) begin
            shift_reg     <= in_data;
            count_reg     <= CNT_LOAD;
            out_valid_reg <= 1'b1;
            in_ready_reg  <= 1'b0;
            busy_reg      <= 1'b1;
`ifdef DEBUG_SERIALIZER_MARKER_EN
            state_reg     <= MARKER;
            out_data_reg  <= DEBUG_MARKER_BYTE;
`else
            state_reg     <= SHIFT;
            out_data_reg  <= in_data[DATA_WIDTH-1 -: 8];
`endif
          end
        end
`ifdef DEBUG_SERIALIZER_MARKER_EN
        MARKER: begin
          if (out_ready) begin
            state_reg    <= SHIFT;
            out_data_reg <= shift_reg[DATA_WIDTH-1 -: 8];
          end
        end
`endif
        SHIFT: begin
          if (out_ready) begin
            shift_reg <= shift_reg << 8;
            if (count_reg == CNT_LAST) begin
              // Last byte handed off; the next word is only accepted once back in IDLE.
              state_reg     <= IDLE;
              out_valid_reg <= 1'b0;
              in_ready_reg  <= 1'b1;
              busy_reg      <= 1'b0;
              out_data_reg  <= '0;
            end else begin
              count_reg    <= count_reg - CNT_LAST;
              out_data_reg <= shift_reg[DATA_WIDTH-9 -: 8];
            end
          end
        end
        default: begin
          state_reg     <= IDLE;
          out_valid_reg <= 1'b0;
          in_ready_reg  <= 1'b1;
          busy_reg      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_debug_word_serializer.sv
// Self-checking bench for debug_word_serializer: vector table, corner sequences, random run
// against a byte-queue scoreboard. Honors DEBUG_SERIALIZER_MARKER_EN.
module tb_debug_word_serializer;

`ifdef DEBUG_SERIALIZER_MARKER_EN
  localparam int NMARK = 1;
`else
  localparam int NMARK = 0;
`endif

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] in_data;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        out_ready;
  logic        busy;

  logic [15:0] in_data16;
  logic        in_valid16;
  logic        in_ready16;
  logic [7:0]  out_data16;
  logic        out_valid16;
  logic        out_ready16;
  logic        busy16;

  always #5 clock = ~clock;

  debug_word_serializer #(.DATA_WIDTH(32)) dut (
    .clock(clock), .reset(reset),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .busy(busy)
  );

  debug_word_serializer #(.DATA_WIDTH(16)) dut16 (
    .clock(clock), .reset(reset),
    .in_data(in_data16), .in_valid(in_valid16), .in_ready(in_ready16),
    .out_data(out_data16), .out_valid(out_valid16), .out_ready(out_ready16),
    .busy(busy16)
  );

  int checks   = 0;
  int failures = 0;

  logic [7:0] exp_q[$];   // scoreboard: bytes still owed by the DUT
  logic [7:0] got_q[$];   // every byte the DUT handed off
  logic [7:0] want_q[$];  // expected bytes for a directed segment
  logic       exp_busy;
  logic       prev_stall = 1'b0;
  logic [7:0] prev_data  = 8'h00;
  logic [7:0] popped;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic want_word(input logic [31:0] w);
    if (NMARK != 0) want_q.push_back(8'hA5);
    for (int i = 3; i >= 0; i--) want_q.push_back(w[i*8 +: 8]);
  endtask

  task automatic compare_got(input string name);
    check({name, "_count"}, 64'(got_q.size()), 64'(want_q.size()));
    for (int i = 0; i < want_q.size(); i++) check(name, got_q[i], want_q[i]);
  endtask

  // Scoreboard monitor for the 32-bit instance; samples between active edges.
  initial forever begin
    @(negedge clock);
    if (reset) begin
      exp_q.delete();
      prev_stall = 1'b0;
    end else begin
      exp_busy = (exp_q.size() != 0);
      check("busy", busy, exp_busy);
      check("in_ready", in_ready, !exp_busy);
      check("out_valid", out_valid, exp_busy);
      if (prev_stall) check("hold_data", out_data, prev_data);
      if (out_valid && out_ready) begin
        got_q.push_back(out_data);
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL spurious_byte: actual=%02h required=none at %0t", out_data, $time);
        end else begin
          popped = exp_q.pop_front();
          check("byte", out_data, popped);
        end
      end
      if (in_valid && in_ready) begin
        if (NMARK != 0) exp_q.push_back(8'hA5);
        for (int i = 3; i >= 0; i--) exp_q.push_back(in_data[i*8 +: 8]);
        $display("accept word %08h at %0t", in_data, $time);
      end
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  typedef struct {
    logic [31:0] word;
    logic [7:0]  ready_pat;   // out_ready per cycle, LSB first, repeating
    logic [31:0] exp_bytes;   // expected data bytes, MSB first
    int          exp_cycles;  // cycles to return to IDLE, 0 = not checked
  } vec_t;

  vec_t vecs[5];
  int   k;

  initial begin
    in_valid = 0; in_data = '0; out_ready = 0;
    in_valid16 = 0; in_data16 = '0; out_ready16 = 0;
    reset = 1;
    repeat (3) tick();
    reset = 0;
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_out_data", out_data, 8'h00);
    check("rst_in_ready", in_ready, 1'b1);
    check("rst_busy", busy, 1'b0);
    check("rst16_in_ready", in_ready16, 1'b1);

    vecs[0] = '{32'h12345678, 8'hFF,        32'h12345678, 4 + NMARK};
    vecs[1] = '{32'hDEADBEEF, 8'b01101001,  32'hDEADBEEF, 0};
    vecs[2] = '{32'h00000000, 8'hFF,        32'h00000000, 4 + NMARK};
    vecs[3] = '{32'hA5A5A5A5, 8'b10101010,  32'hA5A5A5A5, 0};
    vecs[4] = '{32'h80FF0102, 8'b11001100,  32'h80FF0102, 0};

    for (int v = 0; v < 5; v++) begin
      got_q.delete(); want_q.delete();
      out_ready = 0;
      in_data = vecs[v].word; in_valid = 1;
      tick();
      in_valid = 0; in_data = $urandom;
      k = 0;
      while (!in_ready && k < 200) begin
        out_ready = vecs[v].ready_pat[k % 8];
        tick();
        k++;
      end
      check("vec_done", 64'(k < 200), 64'(1));
      want_word(vecs[v].exp_bytes);
      compare_got("vec_byte");
      if (vecs[v].exp_cycles != 0) check("vec_cycles", 64'(k), 64'(vecs[v].exp_cycles));
    end

    // in_valid held high across two words: the second is taken only in IDLE
    got_q.delete(); want_q.delete();
    out_ready = 1; in_valid = 1; in_data = 32'h00000001;
    tick();
    in_data = 32'hFFFFFFFF;
    k = 0;
    while (!in_ready && k < 50) begin tick(); k++; end
    check("b2b_gap", 64'(k), 64'(4 + NMARK));
    tick();
    in_valid = 0;
    k = 0;
    while (!in_ready && k < 50) begin tick(); k++; end
    want_word(32'h00000001);
    want_word(32'hFFFFFFFF);
    compare_got("b2b_byte");

    // reset mid-word after 34 has been handed off
    got_q.delete(); want_q.delete();
    out_ready = 1; in_valid = 1; in_data = 32'h12345678;
    tick();
    in_valid = 0;
    repeat (2 + NMARK) tick();
    reset = 1;
    tick();
    reset = 0;
    check("midrst_out_valid", out_valid, 1'b0);
    check("midrst_in_ready", in_ready, 1'b1);
    check("midrst_out_data", out_data, 8'h00);
    repeat (5) tick();
    if (NMARK != 0) want_q.push_back(8'hA5);
    want_q.push_back(8'h12);
    want_q.push_back(8'h34);
    compare_got("midrst_byte");
    got_q.delete(); want_q.delete();
    in_valid = 1; in_data = 32'hCAFEF00D;
    tick();
    in_valid = 0;
    k = 0;
    while (!in_ready && k < 50) begin tick(); k++; end
    want_word(32'hCAFEF00D);
    compare_got("after_rst_byte");

    // 16-bit instance: BEEF, busy from the cycle after acceptance until the EF transfer
    want_q.delete();
    if (NMARK != 0) want_q.push_back(8'hA5);
    want_q.push_back(8'hBE);
    want_q.push_back(8'hEF);
    check("w16_busy_before", busy16, 1'b0);
    out_ready16 = 1; in_valid16 = 1; in_data16 = 16'hBEEF;
    tick();
    in_valid16 = 0; in_data16 = 16'h1234;
    k = 0;
    while (busy16 && k < 20) begin
      check("w16_valid", out_valid16, 1'b1);
      check("w16_byte", out_data16, want_q[k]);
      tick();
      k++;
    end
    check("w16_cycles", 64'(k), 64'(2 + NMARK));
    check("w16_in_ready", in_ready16, 1'b1);
    check("w16_out_valid", out_valid16, 1'b0);

    // randomized traffic, occasional resets; scoreboard checks every cycle
    for (int c = 0; c < 1500; c++) begin
      in_valid  = ($urandom % 3) != 0;
      in_data   = $urandom;
      out_ready = ($urandom % 4) != 0;
      reset     = ($urandom % 250) == 0;
      tick();
    end
    reset = 0; in_valid = 0; out_ready = 1;
    repeat (20) tick();
    check("drain_empty", 64'(exp_q.size()), 64'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
